// File: rtl/sap1_pkg.sv
// Shared types for the SAP-1 memory arbiter: default widths, owner encoding
// and arbiter FSM states.
package sap1_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;
    localparam int LOCK_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_LD  = 2'd2
    } state_t;

endpackage

// File: rtl/sap1_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not
// own the previous grant wins; force_cpu overrides everything.
module sap1_rr_pick
    import sap1_pkg::*;
(
    input  logic   req_cpu,
    input  logic   req_ld,
    input  owner_t last_owner,
    input  logic   force_cpu,
    output owner_t owner
);

    always_comb begin
        owner = OWN_NONE;
        if (force_cpu) begin
            owner = OWN_CPU;
        end else if (req_cpu && req_ld) begin
            owner = (last_owner == OWN_CPU) ? OWN_LD : OWN_CPU;
        end else if (req_cpu) begin
            owner = OWN_CPU;
        end else if (req_ld) begin
            owner = OWN_LD;
        end
    end

endmodule

// File: rtl/sap1_mem_arbiter.sv
// Single-port program/data RAM arbiter between the CPU sequencer and the
// external loader: round-robin with a bounded loader lock for burst writes.
module sap1_mem_arbiter
    import sap1_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          ld_req,
    input  logic          ld_lock,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          lock_timeout
);

    localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(MAX_LOCK);

    state_t              state, state_nxt;
    owner_t              last_owner, pick, owner;
    logic [LOCK_W-1:0]   lock_cnt, cnt_nxt;
    logic                lock_active, timeout;
    logic                rvalid_any;
    logic [DW-1:0]       rdata_q;

    function automatic logic [LOCK_W-1:0] sat_inc(input logic [LOCK_W-1:0] c);
        return (c == '1) ? c : c + LOCK_W'(1);
    endfunction

    sap1_rr_pick u_pick (
        .req_cpu   (cpu_req),
        .req_ld    (ld_req),
        .last_owner(last_owner),
        .force_cpu (timeout),
        .owner     (pick)
    );

    // A held loader lock beats round-robin until the CPU has waited MAX_LOCK grants.
    always_comb begin
        lock_active = (state == GNT_LD) && ld_lock && ld_req;
        timeout     = lock_active && cpu_req && (lock_cnt >= LOCK_LIM);
        owner       = (lock_active && !timeout) ? OWN_LD : pick;
        cnt_nxt     = (lock_active && !timeout && cpu_req) ? sat_inc(lock_cnt) : '0;
    end

    always_comb begin
        state_nxt = IDLE;
        case (owner)
            OWN_CPU: state_nxt = GNT_CPU;
            OWN_LD:  state_nxt = GNT_LD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Access strobes and address are latched at the grant edge; the requester
    // holds its inputs until the grant, so these equal the owner's inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner   <= OWN_LD;
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rvalid   <= 1'b0;
            ld_rvalid    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            lock_cnt     <= cnt_nxt;
            lock_timeout <= timeout;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            case (owner)
                OWN_CPU: begin
                    last_owner <= OWN_CPU;
                    mem_re     <= ~cpu_we;
                    mem_we     <= cpu_we;
                    mem_addr   <= cpu_addr;
                    mem_wdata  <= cpu_wdata;
                end
                OWN_LD: begin
                    last_owner <= OWN_LD;
                    mem_re     <= ~ld_we;
                    mem_we     <= ld_we;
                    mem_addr   <= ld_addr;
                    mem_wdata  <= ld_wdata;
                end
                default: ;
            endcase
            cpu_rvalid <= cpu_gnt & mem_re;
            ld_rvalid  <= ld_gnt & mem_re;
            if (rvalid_any) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // The RAM output register already supplies the data in the rvalid cycle.
    assign cpu_gnt    = (state == GNT_CPU);
    assign ld_gnt     = (state == GNT_LD);
    assign rvalid_any = cpu_rvalid | ld_rvalid;
    assign rdata      = rvalid_any ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_sap1_mem_arbiter.sv
// Directed bench for sap1_mem_arbiter: a vector table for single-cycle
// behaviour plus sequences for bursts, lock timeout and mid-read reset.
module tb_sap1_mem_arbiter;

    typedef struct packed {
        logic       cg, lg, cv, lv, re, we, to;
        logic [3:0] addr;
        logic [7:0] wd, rd;
    } out_t;

    typedef struct {
        logic       rst;
        logic       creq, cwe;
        logic [3:0] caddr;
        logic [7:0] cwd;
        logic       lreq, llock, lwe;
        logic [3:0] laddr;
        logic [7:0] lwd;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       ld_req, ld_lock, ld_we, ld_gnt, ld_rvalid;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       mem_re, mem_we, lock_timeout;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata, rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sap1_mem_arbiter #(.AW(4), .DW(8), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_lock(ld_lock), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata), .lock_timeout(lock_timeout)
    );

    // Registered RAM model: unwritten locations read a fixed pattern.
    logic [7:0]  wmem [16];
    logic [15:0] wvld;
    logic [7:0]  ram_q;

    function automatic logic [7:0] dflt(input logic [3:0] a);
        return (a == 4'h3) ? 8'hA5 : {a, ~a};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            wvld <= '0;
        end else if (mem_we) begin
            wmem[mem_addr] <= mem_wdata;
            wvld[mem_addr] <= 1'b1;
        end
        if (mem_re) ram_q <= wvld[mem_addr] ? wmem[mem_addr] : dflt(mem_addr);
    end
    assign mem_rdata = ram_q;

    function automatic out_t o(input int cg, lg, cv, lv, re, we, to, addr, wd, rd);
        out_t r;
        r.cg = 1'(cg); r.lg = 1'(lg); r.cv = 1'(cv); r.lv = 1'(lv);
        r.re = 1'(re); r.we = 1'(we); r.to = 1'(to);
        r.addr = 4'(addr); r.wd = 8'(wd); r.rd = 8'(rd);
        return r;
    endfunction

    function automatic vec_t v(input int r, cr, cw, ca, cd, lr, ll, lw, la, ld, input out_t e);
        vec_t x;
        x.rst = 1'(r); x.creq = 1'(cr); x.cwe = 1'(cw); x.caddr = 4'(ca); x.cwd = 8'(cd);
        x.lreq = 1'(lr); x.llock = 1'(ll); x.lwe = 1'(lw); x.laddr = 4'(la); x.lwd = 8'(ld);
        x.exp = e;
        return x;
    endfunction

    function automatic out_t cur();
        out_t r;
        r.cg = cpu_gnt; r.lg = ld_gnt; r.cv = cpu_rvalid; r.lv = ld_rvalid;
        r.re = mem_re; r.we = mem_we; r.to = lock_timeout;
        r.addr = mem_addr; r.wd = mem_wdata; r.rd = rdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 0; ld_lock = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    endtask

    vec_t tbl [14];
    int   n_ld;
    logic got, to_at_cpu, to_bad;

    initial begin
        rst = 1'b1;
        idle_inputs();

        tbl[0]  = v(1, 0,0,0,0,     0,0,0,0,0, o(0,0,0,0,0,0,0,0,0,0));
        tbl[1]  = v(1, 0,0,0,0,     0,0,0,0,0, o(0,0,0,0,0,0,0,0,0,0));
        tbl[2]  = v(0, 1,0,3,0,     0,0,0,0,0, o(1,0,0,0,1,0,0,3,0,0));
        tbl[3]  = v(0, 0,0,0,0,     0,0,0,0,0, o(0,0,1,0,0,0,0,3,0,'hA5));
        tbl[4]  = v(0, 0,0,0,0,     1,0,0,5,0, o(0,1,0,0,1,0,0,5,0,'hA5));
        tbl[5]  = v(0, 1,0,6,0,     1,0,0,7,0, o(1,0,0,1,1,0,0,6,0,'h5A));
        tbl[6]  = v(0, 1,0,6,0,     1,0,0,7,0, o(0,1,1,0,1,0,0,7,0,'h69));
        tbl[7]  = v(0, 1,0,6,0,     1,0,0,7,0, o(1,0,0,1,1,0,0,6,0,'h78));
        tbl[8]  = v(0, 1,0,6,0,     1,0,0,7,0, o(0,1,1,0,1,0,0,7,0,'h69));
        tbl[9]  = v(0, 0,0,0,0,     0,0,0,0,0, o(0,0,0,1,0,0,0,7,0,'h78));
        tbl[10] = v(0, 1,1,15,'h3C, 0,0,0,0,0, o(1,0,0,0,0,1,0,15,'h3C,'h78));
        tbl[11] = v(0, 0,0,0,0,     0,0,0,0,0, o(0,0,0,0,0,0,0,15,'h3C,'h78));
        tbl[12] = v(0, 1,0,15,'h3C, 0,0,0,0,0, o(1,0,0,0,1,0,0,15,'h3C,'h78));
        tbl[13] = v(0, 0,0,0,0,     0,0,0,0,0, o(0,0,1,0,0,0,0,15,'h3C,'h3C));

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
            cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            ld_req = tbl[i].lreq; ld_lock = tbl[i].llock; ld_we = tbl[i].lwe;
            ld_addr = tbl[i].laddr; ld_wdata = tbl[i].lwd;
            step();
            chk($sformatf("vec%0d", i), 32'(cur()), 32'(tbl[i].exp));
        end

        // Locked loader burst with no CPU contention.
        for (int i = 0; i < 16; i++) begin
            ld_req = 1; ld_lock = 1; ld_we = 1;
            ld_addr = 4'(i); ld_wdata = 8'(8'hC0 + i);
            step();
            chk($sformatf("burst%0d", i),
                32'({ld_gnt, mem_we, mem_addr, mem_wdata, lock_timeout, cpu_gnt}),
                32'({1'b1, 1'b1, 4'(i), 8'(8'hC0 + i), 1'b0, 1'b0}));
        end
        idle_inputs();
        cpu_req = 1; cpu_addr = 4'h9;
        step();
        chk("readback_gnt", 32'({cpu_gnt, mem_re, mem_addr}), 32'({1'b1, 1'b1, 4'h9}));
        cpu_req = 0;
        step();
        chk("readback_data", 32'({cpu_rvalid, rdata}), 32'({1'b1, 8'hC9}));

        // Lock timeout: CPU waits behind a locked loader.
        ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 4'h0; ld_wdata = 8'h11;
        step();
        chk("lock_first_ld", 32'(ld_gnt), 32'(1));
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h2;
        n_ld = 0; got = 0; to_at_cpu = 0; to_bad = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (cpu_gnt) begin
                got = 1;
                to_at_cpu = lock_timeout;
                cpu_req = 0;
            end else begin
                if (ld_gnt) n_ld++;
                if (lock_timeout) to_bad = 1;
            end
        end
        chk("lock_cpu_granted", 32'(got), 32'(1));
        chk("lock_ld_regrants", 32'(n_ld), 32'(8));
        chk("lock_timeout_pulse", 32'({to_at_cpu, to_bad}), 32'({1'b1, 1'b0}));
        step();
        chk("after_timeout", 32'({ld_gnt, lock_timeout, cpu_rvalid, rdata}),
            32'({1'b1, 1'b0, 1'b1, 8'hC2}));
        idle_inputs();
        step();

        // Reset during the cycle of a loader read grant.
        ld_req = 1; ld_we = 0; ld_addr = 4'h5;
        step();
        chk("rstmid_gnt", 32'({ld_gnt, mem_re}), 32'({1'b1, 1'b1}));
        rst = 1; ld_req = 0;
        step();
        chk("rstmid_outputs", 32'(cur()), 32'(0));
        rst = 0;
        step();
        chk("rstmid_no_rvalid", 32'(cur()), 32'(0));
        cpu_req = 1; ld_req = 1;
        step();
        chk("rstmid_cpu_first", 32'({cpu_gnt, ld_gnt}), 32'({1'b1, 1'b0}));
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
